// File: rtl/acq_sequencer.sv
// Ultrasound shot controller: fire pulse, wait dead time, capture N samples, then hand the
// single RAM address port over to the host for readout.
module acq_sequencer #(
  parameter int ADDRSIZE  = 7,
  parameter int PULSE_LEN = 4,
  parameter int DELAY_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DELAY_W-1:0]  delay_cfg,
  input  logic [ADDRSIZE:0]   nsample_cfg,
  output logic                pulse_out,
  output logic                en_write,
  output logic [ADDRSIZE-1:0] ram_addr,
  input  logic                rd_req,
  input  logic [ADDRSIZE-1:0] rd_addr,
  output logic                rd_valid,
  output logic                busy,
  output logic                done
);

  localparam int PW    = $clog2(PULSE_LEN + 1);
  localparam int CNT_W = (DELAY_W > PW) ? DELAY_W : PW;
  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  typedef enum logic [2:0] {IDLE, PULSE, DELAY, ACQ, READ} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [ADDRSIZE-1:0]   addr_reg, addr_next;
  logic [ADDRSIZE-1:0]   last_reg, last_next;
  logic [DELAY_W-1:0]    delay_reg, delay_next;
  logic                  done_reg, done_next;
  logic                  rd_valid_reg, rd_valid_next;
  logic                  accept;
  logic [ADDRSIZE:0]     n_clamp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      last_reg     <= '0;
      delay_reg    <= '0;
      done_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      last_reg     <= last_next;
      delay_reg    <= delay_next;
      done_reg     <= done_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  // Effective sample count: 0 behaves as 1, anything beyond the RAM depth is clamped.
  always_comb begin
    n_clamp = nsample_cfg;
    if (nsample_cfg == '0)
      n_clamp = {{ADDRSIZE{1'b0}}, 1'b1};
    else if (nsample_cfg > DEPTH)
      n_clamp = DEPTH;
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    last_next     = last_reg;
    delay_next    = delay_reg;
    done_next     = 1'b0;
    rd_valid_next = 1'b0;
    pulse_out     = 1'b0;
    en_write      = 1'b0;
    busy          = 1'b0;
    ram_addr      = '0;
    accept        = start && (state_reg == IDLE || state_reg == READ);

    if (accept) begin
      state_next = PULSE;
      cnt_next   = '0;
      addr_next  = '0;
      delay_next = delay_cfg;
      last_next  = ADDRSIZE'(n_clamp - 1'b1);
    end

    case (state_reg)
      PULSE: begin
        pulse_out = 1'b1;
        busy      = 1'b1;
        if (cnt_reg == CNT_W'(PULSE_LEN - 1)) begin
          cnt_next   = '0;
          addr_next  = '0;
          state_next = (delay_reg == '0) ? ACQ : DELAY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DELAY: begin
        busy = 1'b1;
        if (cnt_reg + CNT_W'(1) == CNT_W'(delay_reg)) begin
          cnt_next   = '0;
          state_next = ACQ;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ACQ: begin
        busy     = 1'b1;
        en_write = 1'b1;
        ram_addr = addr_reg;
        if (addr_reg == last_reg) begin
          state_next = READ;
          done_next  = 1'b1;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      READ: begin
        ram_addr = rd_addr;
        // A new shot takes priority over a simultaneous read request.
        rd_valid_next = rd_req && !start;
      end
      default: ;
    endcase

    done     = done_reg;
    rd_valid = rd_valid_reg;
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: shot timing, clamping, readout, collisions and reset.
module tb_acq_sequencer;

  localparam int ADDRSIZE  = 7;
  localparam int PULSE_LEN = 4;
  localparam int DELAY_W   = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [DELAY_W-1:0]  delay_cfg = '0;
  logic [ADDRSIZE:0]   nsample_cfg = '0;
  logic                pulse_out, en_write, rd_valid, busy, done;
  logic [ADDRSIZE-1:0] ram_addr;
  logic                rd_req = 1'b0;
  logic [ADDRSIZE-1:0] rd_addr = '0;

  int errors = 0;
  int checks = 0;

  acq_sequencer #(.ADDRSIZE(ADDRSIZE), .PULSE_LEN(PULSE_LEN), .DELAY_W(DELAY_W)) dut (
    .clk(clk), .reset(reset), .start(start), .delay_cfg(delay_cfg),
    .nsample_cfg(nsample_cfg), .pulse_out(pulse_out), .en_write(en_write),
    .ram_addr(ram_addr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start and observes the shot until done (bounded). With disturb set,
  // start is held high and the config changed from cycle 2 on, to prove they are ignored.
  task automatic run_shot(input int dly, input int n, input bit disturb,
                          output int first_w, output int nw, output int npulse,
                          output int ngap, output bit addr_ok, output int ndone,
                          output int cycles);
    first_w = -1; nw = 0; npulse = 0; ngap = 0; addr_ok = 1'b1; ndone = 0; cycles = 0;
    delay_cfg   = DELAY_W'(dly);
    nsample_cfg = (ADDRSIZE + 1)'(n);
    start       = 1'b1;
    while (cycles < 400) begin
      tick();
      cycles++;
      start = 1'b0;
      if (pulse_out) npulse++;
      if (busy && !pulse_out && !en_write) ngap++;
      if (en_write) begin
        if (first_w < 0) first_w = cycles;
        if (ram_addr !== nw[ADDRSIZE-1:0]) addr_ok = 1'b0;
        nw++;
      end
      if (done) begin
        ndone++;
        break;
      end
      if (disturb && cycles >= 2) begin
        start       = 1'b1;
        delay_cfg   = '0;
        nsample_cfg = 8'd50;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({pulse_out, en_write, busy, done, rd_valid, ram_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {pulse_out, en_write, busy, done, rd_valid, ram_addr});
    end
    reset = 1'b0;
    rd_req = 1'b1; rd_addr = 7'd9;
    tick();
    checks++;
    if ({busy, rd_valid, ram_addr} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rd_valid=%b ram_addr=%0d, expected 0/0/0",
               busy, rd_valid, ram_addr);
    end
    rd_req = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int fw, nw, np, ng, nd, cy; bit ok;
    run_shot(3, 10, 1'b0, fw, nw, np, ng, ok, nd, cy);
    checks++; if (np !== 4) begin errors++; $display("FAIL basic_pulse: got %0d, expected 4", np); end
    checks++; if (ng !== 3) begin errors++; $display("FAIL basic_gap: got %0d, expected 3", ng); end
    checks++; if (fw !== 8) begin errors++; $display("FAIL basic_latency: got %0d, expected 8", fw); end
    checks++; if (nw !== 10) begin errors++; $display("FAIL basic_writes: got %0d, expected 10", nw); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_addr: got %b, expected 1", ok); end
    checks++; if (nd !== 1 || cy !== 18) begin
      errors++; $display("FAIL basic_done: got done=%0d at cycle %0d, expected 1 at 18", nd, cy);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_read_busy: got %b, expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_strobe: got %b, expected 0", done); end
    $display("test_basic: writes=%0d first=%0d", nw, fw);
  endtask

  task automatic test_zero();
    int fw, nw, np, ng, nd, cy; bit ok;
    run_shot(0, 0, 1'b0, fw, nw, np, ng, ok, nd, cy);
    checks++; if (ng !== 0 || fw !== 5) begin
      errors++; $display("FAIL zero_latency: gap=%0d first=%0d, expected 0 and 5", ng, fw);
    end
    checks++; if (nw !== 1 || ok !== 1'b1 || nd !== 1) begin
      errors++; $display("FAIL zero_writes: writes=%0d addr_ok=%b done=%0d, expected 1/1/1", nw, ok, nd);
    end
    $display("test_zero: writes=%0d first=%0d", nw, fw);
  endtask

  task automatic test_clamp();
    int fw, nw, np, ng, nd, cy; bit ok;
    run_shot(1, 200, 1'b0, fw, nw, np, ng, ok, nd, cy);
    checks++; if (nw !== 128) begin errors++; $display("FAIL clamp_writes: got %0d, expected 128", nw); end
    checks++; if (ok !== 1'b1 || nd !== 1 || cy !== 134) begin
      errors++; $display("FAIL clamp_seq: addr_ok=%b done=%0d cycle=%0d, expected 1/1/134", ok, nd, cy);
    end
    $display("test_clamp: writes=%0d", nw);
  endtask

  task automatic test_readout();
    int i;
    rd_req = 1'b1; rd_addr = 7'd5;
    #1;
    checks++; if (ram_addr !== 7'd5) begin errors++; $display("FAIL read_addr: got %0d, expected 5", ram_addr); end
    tick();
    rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b, expected 1", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop: got %b, expected 0", rd_valid); end
    // Read request during capture must be ignored.
    delay_cfg = '0; nsample_cfg = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 20 && !en_write; i++) tick();
    checks++; if (en_write !== 1'b1) begin errors++; $display("FAIL acq_reached: got %b, expected 1", en_write); end
    rd_req = 1'b1; rd_addr = 7'd99;
    #1;
    checks++; if (ram_addr !== 7'd0) begin errors++; $display("FAIL acq_addr0: got %0d, expected 0", ram_addr); end
    tick();
    checks++; if (ram_addr !== 7'd1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL acq_read_ignored: addr=%0d rd_valid=%b, expected 1/0", ram_addr, rd_valid);
    end
    rd_req = 1'b0;
    for (i = 0; i < 20 && !done; i++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL acq_done_timeout: got %b, expected 1", done); end
    $display("test_readout done");
  endtask

  task automatic test_collisions();
    int fw, nw, np, ng, nd, cy, i; bit ok;
    run_shot(5, 3, 1'b1, fw, nw, np, ng, ok, nd, cy);
    checks++; if (fw !== 10 || ng !== 5) begin
      errors++; $display("FAIL busy_start_ignored: first=%0d gap=%0d, expected 10/5", fw, ng);
    end
    checks++; if (nw !== 3 || ok !== 1'b1 || nd !== 1) begin
      errors++; $display("FAIL cfg_latch: writes=%0d addr_ok=%b done=%0d, expected 3/1/1", nw, ok, nd);
    end
    delay_cfg = '0; nsample_cfg = 8'd2;
    start = 1'b1; rd_req = 1'b1; rd_addr = 7'd3;
    tick();
    start = 1'b0; rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b0 || pulse_out !== 1'b1) begin
      errors++; $display("FAIL start_wins: rd_valid=%b pulse=%b, expected 0/1", rd_valid, pulse_out);
    end
    for (i = 0; i < 30 && !done; i++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL start_wins_done: got %b, expected 1", done); end
    $display("test_collisions done");
  endtask

  task automatic test_reset_mid_acq();
    int fw, nw, np, ng, nd, cy, i; bit ok;
    delay_cfg = 8'd2; nsample_cfg = 8'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 40 && !(en_write && ram_addr == 7'd4); i++) tick();
    checks++; if (!(en_write === 1'b1 && ram_addr === 7'd4)) begin
      errors++; $display("FAIL mid_acq_reach: en=%b addr=%0d, expected 1/4", en_write, ram_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({pulse_out, en_write, busy, done, rd_valid, ram_addr} !== '0) begin
      errors++; $display("FAIL mid_acq_reset: got %b, expected all zero",
                         {pulse_out, en_write, busy, done, rd_valid, ram_addr});
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_acq_no_done: done=%b busy=%b, expected 0/0", done, busy);
    end
    run_shot(2, 6, 1'b0, fw, nw, np, ng, ok, nd, cy);
    checks++; if (fw !== 7 || nw !== 6 || ok !== 1'b1 || nd !== 1) begin
      errors++; $display("FAIL post_reset_shot: first=%0d writes=%0d addr_ok=%b done=%0d, expected 7/6/1/1",
                         fw, nw, ok, nd);
    end
    $display("test_reset_mid_acq done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readout();
    test_zero();
    test_clamp();
    test_collisions();
    test_reset_mid_acq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
